// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX -> MEM pipeline register built as a two-entry skid buffer (main + skid).
// The main entry is always what the out_* ports present. in_ready depends only
// on registered state, so there is no combinational path from out_ready back
// to in_ready. Taken branches are resolved when the bundle is accepted and
// raise a one-cycle redirect pulse with the target pc + imm.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   alu_result, zero         ALU result and zero flag
//   rs2_data, rd, pc, imm    store data, destination reg, PC, branch offset
//   reg_write, mem_read,
//   mem_write, branch,
//   branch_type              control bits, branch funct3
//   out_valid / out_ready    downstream handshake
//   out_alu_result,
//   out_rs2_data, out_rd,
//   out_reg_write,
//   out_mem_read,
//   out_mem_write            main-entry payload
//   redirect_valid,
//   redirect_pc              taken-branch pulse and target
//   flush                    drop every held entry
// ---------------------------------------------------------------------------
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic [2:0]  branch_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_rs2_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        flush
);

    // Payload carried downstream: {alu_result, rs2_data, rd, reg_write, mem_read, mem_write}
    localparam int BW = 32 + 32 + 5 + 3;

    logic [BW-1:0] w_in_bundle;
    logic [BW-1:0] r_main;
    logic [BW-1:0] r_skid;
    logic          r_main_valid;
    logic          r_skid_valid;
    logic          r_redirect_valid;
    logic [31:0]   r_redirect_pc;
    logic          w_accept;
    logic          w_xfer;
    logic          w_taken;

    assign w_in_bundle = {alu_result, rs2_data, rd, reg_write, mem_read, mem_write};

    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid & ~flush;
    assign w_xfer   = r_main_valid & out_ready;

    // Branch condition from funct3; the ALU has already produced either the
    // equality flag (BEQ/BNE) or a set-less-than bit in alu_result[0].
    always_comb begin
        w_taken = 1'b0;
        case (branch_type)
            3'b000:         w_taken = zero;
            3'b001:         w_taken = ~zero;
            3'b100, 3'b110: w_taken = alu_result[0];
            3'b101, 3'b111: w_taken = ~alu_result[0];
            default:        w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main           <= '0;
            r_skid           <= '0;
            r_main_valid     <= 1'b0;
            r_skid_valid     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (r_skid_valid) begin
                // Full: in_ready is low, so only a shift skid -> main can happen.
                if (w_xfer) begin
                    r_main       <= r_skid;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept && r_main_valid && !w_xfer) begin
                // Main is stalled: park the new bundle in the skid slot.
                r_skid       <= w_in_bundle;
                r_skid_valid <= 1'b1;
            end else if (w_accept) begin
                // Empty, or main leaving this cycle: new bundle goes to main.
                r_main       <= w_in_bundle;
                r_main_valid <= 1'b1;
            end else if (w_xfer) begin
                r_main_valid <= 1'b0;
            end

            // w_accept already excludes flush, so a flushed branch never redirects.
            r_redirect_valid <= w_accept & branch & w_taken;
            if (w_accept && branch && w_taken) begin
                r_redirect_pc <= pc + imm;
            end
        end
    end

    assign out_valid = r_main_valid;
    assign {out_alu_result, out_rs2_data, out_rd,
            out_reg_write, out_mem_read, out_mem_write} = r_main;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule
